// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS retire-trace monitor: FSM states, capture modes,
// event-kind flags and the capture qualifier.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ALL   = 2'd0;
    localparam logic [1:0] MODE_REGWR = 2'd1;
    localparam logic [1:0] MODE_MEMBR = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam int KIND_REG_BIT = 0;
    localparam int KIND_MEM_BIT = 1;
    localparam int KIND_BR_BIT  = 2;
    localparam int KIND_W       = 3;

    // Bit order matches out_kind: {taken_branch, mem_write, reg_write}.
    typedef struct packed {
        logic taken_branch;
        logic mem_write;
        logic reg_write;
    } kind_t;

    // Reserved mode falls through to capture-everything.
    function automatic logic capture_qualify(input logic [1:0] mode, input kind_t k);
        case (mode)
            MODE_REGWR: return k.reg_write;
            MODE_MEMBR: return k.mem_write | k.taken_branch;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees the slot that a
// same-cycle push into a full FIFO needs, so full+push+pop loses nothing.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_valid   = !w_empty;
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop && !w_empty && !i_flush;
    assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_flush;

    // Head fields read as zero whenever nothing is queued.
    assign o_data = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mips_trace_monitor.sv
// Run/cycle-budget controller and retire-event filter sitting beside the MIPS
// core; qualified events are queued in trace_fifo and drained over valid/ready.
module mips_trace_monitor
    import mips_trace_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 16,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instruction,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [REG_AW-1:0] out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic [CYC_W-1:0]  out_cycle,
    output logic [2:0]        out_kind,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              done,
    output logic              busy
);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [REG_AW-1:0] wreg;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cycle;
        kind_t             kind;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    state_t             r_state;
    logic [CYC_W-1:0]   r_cycle;
    logic               r_overflow;
    logic               r_done;
    logic               r_busy;

    kind_t              w_kind;
    entry_t             w_entry_in;
    entry_t             w_entry_out;
    logic [ENTRY_W-1:0] w_fifo_out;
    logic               w_qual;
    logic               w_pop;
    logic               w_full;
    logic               w_valid;
    logic               w_drop;
    logic               w_flush;
    logic               w_last;
    logic [CNT_W-1:0]   w_count;

    assign w_kind = '{taken_branch: branch & zero, mem_write: mem_write, reg_write: reg_write};

    assign w_entry_in = '{pc:    pc_in,
                          instr: instruction,
                          wreg:  write_reg,
                          data:  write_data,
                          cycle: r_cycle,
                          kind:  w_kind};

    assign w_qual  = (r_state == ST_RUN) && capture_qualify(mode, w_kind);
    assign w_pop   = w_valid && out_ready;
    assign w_drop  = w_qual && w_full && !w_pop;
    assign w_flush = (r_state == ST_IDLE) && enable;
    // A zero limit never matches, so the counter free-runs and wraps.
    assign w_last  = (cycle_limit != '0) && (r_cycle == cycle_limit - CYC_W'(1));

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_flush (w_flush),
        .i_push  (w_qual),
        .i_pop   (w_pop),
        .i_data  (w_entry_in),
        .o_data  (w_fifo_out),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cycle    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state    <= ST_RUN;
                        r_cycle    <= '0;
                        r_overflow <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cycle <= r_cycle + CYC_W'(1);
                    if (w_drop) r_overflow <= 1'b1;
                    if (!enable || w_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_count == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_entry_out = w_fifo_out;
    assign out_valid   = w_valid;
    assign out_pc      = w_entry_out.pc;
    assign out_instr   = w_entry_out.instr;
    assign out_reg     = w_entry_out.wreg;
    assign out_data    = w_entry_out.data;
    assign out_cycle   = w_entry_out.cycle;
    assign out_kind    = w_entry_out.kind;
    assign count       = w_count;
    assign overflow    = r_overflow;
    assign done        = r_done;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Directed bench for mips_trace_monitor: hand-computed entries per run.
module tb_mips_trace_monitor;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] cycle_limit;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        mem_write;
    logic        branch;
    logic        zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_reg;
    logic [31:0] out_data;
    logic [15:0] out_cycle;
    logic [2:0]  out_kind;
    logic [4:0]  count;
    logic        overflow;
    logic        done;
    logic        busy;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [15:0] cyc;
        logic [2:0]  kind;
    } ent_t;

    ent_t got[$];
    int   n_checks;
    int   n_errors;

    mips_trace_monitor #(
        .DATA_W (32),
        .REG_AW (5),
        .DEPTH  (16),
        .CYC_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .cycle_limit (cycle_limit),
        .pc_in       (pc_in),
        .instruction (instruction),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .mem_write   (mem_write),
        .branch      (branch),
        .zero        (zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_reg     (out_reg),
        .out_data    (out_data),
        .out_cycle   (out_cycle),
        .out_kind    (out_kind),
        .count       (count),
        .overflow    (overflow),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record any entry handed over at the coming edge, then advance to the next negedge.
    task automatic step();
        ent_t e;
        if (out_valid && out_ready) begin
            e.pc = out_pc; e.rg = out_reg; e.data = out_data;
            e.cyc = out_cycle; e.kind = out_kind;
            got.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pc_in = '0; instruction = '0; reg_write = 1'b0; write_reg = '0;
        write_data = '0; mem_write = 1'b0; branch = 1'b0; zero = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; out_ready = 1'b0; mode = 2'd0; cycle_limit = '0;
        clear_inputs();
        step(); step();
        rst = 1'b1;
        step();
        got.delete();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && !done; i++) step();
        check(tag, done, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        @(negedge clk);
        do_reset();

        // Reset values
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_pc", out_pc, 32'd0);

        // Reset in the middle of a run after three captures
        mode = 2'd0; enable = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            pc_in = 32'h100 + 32'(k * 4);
            step();
        end
        check("midrun_count_before", count, 5'd3);
        rst = 1'b0;
        #1;
        check("midrun_count", count, 5'd0);
        check("midrun_valid", out_valid, 1'b0);
        check("midrun_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        pc_in = 32'h200;
        step();
        check("restart_valid", out_valid, 1'b1);
        check("restart_cycle", out_cycle, 16'd0);
        check("restart_pc", out_pc, 32'h200);

        // mode 0, limit 5, consumer always ready
        do_reset();
        mode = 2'd0; cycle_limit = 16'd5; out_ready = 1'b1; enable = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            pc_in = 32'h400 + 32'(k * 4);
            step();
        end
        check("m0_busy_after_run", busy, 1'b1);
        wait_done("m0_done");
        check("m0_entries", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) begin
            check($sformatf("m0_cycle%0d", i), got[i].cyc, 16'(i));
            check($sformatf("m0_pc%0d", i), got[i].pc, 32'h400 + 32'(i * 4));
        end
        check("m0_count", count, 5'd0);
        enable = 1'b0;
        step();
        check("m0_idle_done", done, 1'b0);
        check("m0_idle_busy", busy, 1'b0);

        // mode 1: register writes on cycles 2 and 7 only
        do_reset();
        mode = 2'd1; cycle_limit = 16'd10; out_ready = 1'b1; enable = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            clear_inputs();
            pc_in = 32'h800 + 32'(k * 4);
            if (k == 2) begin reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h2A; end
            if (k == 7) begin reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h77; end
            if (k == 4) mem_write = 1'b1;
            step();
        end
        clear_inputs();
        wait_done("m1_done");
        check("m1_entries", got.size(), 2);
        if (got.size() >= 2) begin
            check("m1_reg", got[0].rg, 5'd8);
            check("m1_data", got[0].data, 32'h2A);
            check("m1_kind", got[0].kind, 3'b001);
            check("m1_cycle", got[0].cyc, 16'd2);
            check("m1_pc", got[0].pc, 32'h808);
            check("m1_cycle2", got[1].cyc, 16'd7);
            check("m1_reg2", got[1].rg, 5'd3);
        end

        // mode 2: untaken branch and plain reg write are filtered out
        do_reset();
        mode = 2'd2; cycle_limit = 16'd8; out_ready = 1'b1; enable = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            if (k == 1) reg_write = 1'b1;
            if (k == 3) branch = 1'b1;
            if (k == 4) begin branch = 1'b1; zero = 1'b1; end
            if (k == 5) mem_write = 1'b1;
            if (k == 6) zero = 1'b1;
            step();
        end
        wait_done("m2_done");
        check("m2_entries", got.size(), 2);
        if (got.size() >= 2) begin
            check("m2_cycle0", got[0].cyc, 16'd4);
            check("m2_kind0", got[0].kind, 3'b100);
            check("m2_cycle1", got[1].cyc, 16'd5);
            check("m2_kind1", got[1].kind, 3'b010);
        end

        // Overflow: no consumer, 20 events into 16 slots
        do_reset();
        mode = 2'd0; cycle_limit = 16'd20; out_ready = 1'b0; enable = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            pc_in = 32'h1000 + 32'(k);
            step();
        end
        check("ovf_count", count, 5'd16);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_head_cycle", out_cycle, 16'd0);
        check("ovf_busy", busy, 1'b1);
        check("ovf_not_done", done, 1'b0);
        out_ready = 1'b1;
        wait_done("ovf_done");
        check("ovf_entries", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++)
            check($sformatf("ovf_cycle%0d", i), got[i].cyc, 16'(i));
        check("ovf_sticky", overflow, 1'b1);
        enable = 1'b0;
        step();

        // Full FIFO with a pop in the same cycle as a capture; new run clears overflow
        mode = 2'd0; cycle_limit = 16'd17; out_ready = 1'b0; enable = 1'b1;
        got.delete();
        step();
        check("fp_ovf_cleared", overflow, 1'b0);
        for (int k = 0; k < 17; k++) begin
            if (k == 16) out_ready = 1'b1;
            pc_in = 32'h2000 + 32'(k);
            step();
        end
        check("fp_count", count, 5'd16);
        check("fp_overflow", overflow, 1'b0);
        check("fp_head_cycle", out_cycle, 16'd1);
        wait_done("fp_done");
        check("fp_entries", got.size(), 17);
        for (int i = 0; i < got.size() && i < 17; i++)
            check($sformatf("fp_cycle%0d", i), got[i].cyc, 16'(i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
